// File: rtl/nibble_serial_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_alu_if
//  Brief    : Operand/result handshake bundle for the nibble-serial ALU.
//             master = operand source + result consumer, slave = the ALU.
//  Revision : 1.0  initial release
// ============================================================================
interface nibble_serial_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_alu
//  Brief    : WIDTH-bit ALU computed one nibble per clock, LS nibble first,
//             with a registered carry between nibbles. Valid/ready on both
//             the operand and result sides.
//             Optional feature macro: ALU_SERIAL_SLT_EN (alu_op 111 = SLT;
//             when undefined, 111 behaves as SUB).
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_alu #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serial_alu_if.slave  bus
);
    localparam int c_nib   = WIDTH / 4;
    localparam int c_idx_w = (c_nib > 1) ? $clog2(c_nib) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_nib - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
        $error("nibble_serial_alu: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [2:0]         op_q,     op_d;
    logic               carry_q,  carry_d;
    logic [c_idx_w-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;

    // Nibble datapath (one 4-bit slice, reused every RUN cycle)
    logic             w_is_sub;
    logic             w_is_arith;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_raw;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_sum;
    logic             w_c_msb_in;
    logic             w_ovf;
    logic             w_carry_next;
    logic [3:0]       w_nib_val;

    assign w_is_sub     = (op_q == 3'b110) || (op_q == 3'b111);
    assign w_is_arith   = (op_q == 3'b010) || w_is_sub;
    assign w_a_sh       = a_q >> {idx_q, 2'b00};
    assign w_b_sh       = b_q >> {idx_q, 2'b00};
    assign w_a_nib      = w_a_sh[3:0];
    assign w_b_raw      = w_b_sh[3:0];
    assign w_b_nib      = w_is_sub ? ~w_b_raw : w_b_raw;
    assign w_sum        = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, carry_q};
    // Carry into bit 3 recovered from the sum bit: s3 = a3 ^ b3 ^ c3
    assign w_c_msb_in   = w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3];
    assign w_ovf        = w_is_arith & (w_c_msb_in ^ w_sum[4]);
    assign w_carry_next = w_is_arith ? w_sum[4] : carry_q;

    // Operation select for the current nibble; unlisted opcodes produce zero
    always_comb begin
        w_nib_val = 4'h0;
        case (op_q)
            3'b000:  w_nib_val = w_a_nib & w_b_raw;
            3'b001:  w_nib_val = w_a_nib | w_b_raw;
            3'b010,
            3'b110,
            3'b111:  w_nib_val = w_sum[3:0];
            default: w_nib_val = 4'h0;
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    op_d     = bus.alu_op;
                    carry_d  = (bus.alu_op == 3'b110) || (bus.alu_op == 3'b111);
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = w_nib_val;
                carry_d = w_carry_next;
                idx_d   = idx_q + 1'b1;
                if (idx_q == c_last) begin
`ifdef ALU_SERIAL_SLT_EN
                    // Less-than: sign of the difference corrected by overflow
                    if (op_q == 3'b111) begin
                        result_d = {{(WIDTH-1){1'b0}}, w_sum[3] ^ w_ovf};
                    end
`endif
                    cout_d  = w_is_arith & w_sum[4];
                    ovf_d   = w_ovf;
                    zero_d  = (result_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_alu
//  Brief    : Directed self-checking bench for nibble_serial_alu (WIDTH=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_alu;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    nibble_serial_alu_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for out_valid; leaves the result
    // pending in DONE with out_ready low.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, output int lat);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.alu_op   = op;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1) lat++;
        end
        if (bus.out_valid !== 1'b1) lat = 99;
    endtask

    task automatic accept();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [15:0] exp_res,
                          input logic exp_c, input logic exp_v, input logic exp_z);
        int lat;
        issue(a, b, op, lat);
        check({tag, " latency"},   32'(lat),       32'd4);
        check({tag, " result"},    32'(bus.result), 32'(exp_res));
        check({tag, " carry_out"}, 32'(bus.carry_out), 32'(exp_c));
        check({tag, " overflow"},  32'(bus.overflow),  32'(exp_v));
        check({tag, " zero"},      32'(bus.zero),      32'(exp_z));
        accept();
        check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready back"},  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        int lat;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_op    = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result",    32'(bus.result),    32'd0);
        check("reset flags",     {29'd0, bus.carry_out, bus.overflow, bus.zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 16'h7FFF, 16'h0001, 3'b010, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_eq",  16'h0005, 16'h0005, 3'b110, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_brw", 16'h0000, 16'h0001, 3'b110, 16'hFFFF, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SERIAL_SLT_EN
        run_op("slt",     16'hFFFF, 16'h0001, 3'b111, 16'h0001, 1'b1, 1'b0, 1'b0);
`else
        run_op("slt_sub", 16'hFFFF, 16'h0001, 3'b111, 16'hFFFE, 1'b1, 1'b0, 1'b0);
`endif
        run_op("or",      16'hF0F0, 16'h3C3C, 3'b001, 16'hFCFC, 1'b0, 1'b0, 1'b0);
        run_op("op101",   16'h1234, 16'h5678, 3'b101, 16'h0000, 1'b0, 1'b0, 1'b1);

        // AND with back-pressure: hold out_ready low and push a stray request
        issue(16'hF0F0, 16'h3C3C, 3'b000, lat);
        check("and latency", 32'(lat), 32'd4);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.alu_op   = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("and hold out_valid", 32'(bus.out_valid), 32'd1);
            check("and hold in_ready",  32'(bus.in_ready),  32'd0);
            check("and hold result",    32'(bus.result),    32'h3030);
            check("and hold flags", {29'd0, bus.carry_out, bus.overflow, bus.zero}, 32'd0);
        end
        bus.in_valid = 1'b0;
        accept();
        check("and in_ready back", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("stray req ignored", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of RUN discards the partial result
        @(negedge clk);
        bus.a        = 16'hFFFF;
        bus.b        = 16'h0000;
        bus.alu_op   = 3'b010;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset partial", 32'(bus.result), 32'h00FF);
        rst_n = 1'b0;
        #1;
        check("midrun rst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrun rst result",    32'(bus.result),    32'd0);
        check("midrun rst in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_post", 16'h1234, 16'h1111, 3'b010, 16'h2345, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/nibble_serial_alu.md
# nibble_serial_alu

Multi-cycle, area-reduced ALU that processes WIDTH-bit operands one 4-bit nibble per clock, least-significant nibble first, with a registered carry between nibbles. It supplies the sequential driver and result collector for the 4-bit carry-lookahead slice datapath: it feeds operand nibbles and carry-in each cycle, then assembles the result and flags. Valid/ready handshakes on both input and output let it sit between an operand source and a result consumer in the ALU subsystem.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8; NIB = WIDTH/4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block idle, can accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_op  input  3  operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- carry_out  output  1  final carry (SUB/SLT: 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  result == 0

## Operation
- FSM states: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE: on in_valid & in_ready, latch a, b, alu_op; carry reg = 1 for SUB/SLT, else 0; nibble index = 0; result reg = 0; go RUN.
- RUN: each cycle operates on nibble[idx] of a and b. b nibble inverted for SUB/SLT. ADD/SUB/SLT: sum nibble = a + b' + carry; carry reg <= nibble carry-out. AND/OR: bitwise, carry unchanged. Write the nibble into result[4*idx+3:4*idx]; idx++. After nibble NIB-1, go DONE.
- Flags, latched entering DONE: carry_out = final carry (0 for AND/OR); overflow = carry into MSB XOR carry out of MSB for ADD/SUB/SLT, else 0; zero = (final result == 0).
- SLT: result = {WIDTH-1 zeros, (MSB of difference) XOR overflow}; carry_out and overflow report the underlying subtraction.
- Unlisted alu_op (011, 100, 101): result 0, carry_out 0, overflow 0, zero 1.
- DONE: outputs stable until out_valid & out_ready, then go IDLE. in_valid ignored outside IDLE.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset (async, rst_n low): state IDLE, in_ready 1, out_valid 0, result 0, carry_out 0, overflow 0, zero 0, internal regs 0. Takes effect immediately, including mid-RUN or in DONE; partial result discarded.
- Accept on edge E0; RUN occupies edges E1..E_NIB; out_valid high after E_NIB (NIB cycles after acceptance; 4 for WIDTH=16).
- Output handshake edge returns to IDLE; in_ready high the next cycle. Minimum issue interval NIB+2 cycles; no overlap of consecutive ops.
- out_ready is ignored except in DONE; out_ready held high yields a one-cycle DONE.
- All outputs registered; in_ready/out_valid are decoded from state flops only (no input-to-output combinational path).

## Configuration
- ALU_SERIAL_SLT_EN defined: alu_op 111 performs SLT as above.
- Not defined: 111 behaves exactly as SUB (full difference in result; flags as SUB); SLT packing logic removed.

## Test plan
- WIDTH=16, ADD 0x7FFF + 0x0001 -> result 0x8000, overflow 1, carry_out 0, zero 0; out_valid exactly 4 cycles after accept edge.
- SUB 0x0005 - 0x0005 -> result 0x0000, zero 1, carry_out 1, overflow 0; SUB 0x0000 - 0x0001 -> 0xFFFF, carry_out 0.
- SLT a=0xFFFF, b=0x0001 -> result 0x0001 with ALU_SERIAL_SLT_EN; without macro -> result 0xFFFE, carry_out 1, overflow 0.
- AND 0xF0F0 & 0x3C3C -> 0x3030; OR -> 0xFCFC; carry_out 0, overflow 0; out_ready held low 3 cycles -> outputs stable, in_ready 0, concurrent in_valid ignored.
- rst_n pulsed low after 2 RUN cycles -> immediately out_valid 0, result 0, in_ready 1; subsequent ADD 0x1234 + 0x1111 -> 0x2345.
- alu_op 101 -> result 0x0000, zero 1, carry_out 0, overflow 0, normal latency.
